// File: rtl/ysyx_22040931_mdu.sv
// ysyx_22040931_mdu -- multi-cycle multiply/divide unit for the RV64M execute stage.
//
// Covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the 32-bit W forms.
// Multiply is unsigned shift-add on operand magnitudes, MUL_BITS multiplier
// bits per cycle. Divide is restoring, one quotient bit per cycle. One
// operation is in flight at a time. A flush kills it.
//
// Optional feature macro: YSYX_22040931_MDU_EARLY_OUT_EN
//   When defined, divide-by-zero, signed overflow and multiplies with a zero
//   operand go straight from IDLE to DONE on the accept edge.
//   When undefined, every operation takes the full step count.
//   The results are the same in both builds.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   flush      in   synchronous kill of the in-flight or pending operation
//   in_valid   in   request valid
//   in_ready   out  request ready (IDLE and no flush)
//   op         in   0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   w          in   32-bit word form (used by op 0 and ops 4-7)
//   num1       in   dividend / multiplicand
//   num2       in   divisor / multiplier
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts the result
//   out_result out  registered result
//   busy       out  unit not IDLE
module ysyx_22040931_mdu #(
  parameter int XLEN     = 64,
  parameter int MUL_BITS = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            w,
  input  logic [XLEN-1:0] num1,
  input  logic [XLEN-1:0] num2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [PW-1:0]   dword_t;

  // Extend a 32-bit value to XLEN. The size cast of a signed operand sign-extends.
  function automatic word_t ext32(input logic [31:0] v, input logic s);
    return s ? word_t'(signed'(v)) : word_t'(v);
  endfunction

  // Final result formation. The special cases override the datapath value.
  // W results are always sign-extended from bit 31.
  function automatic word_t form_result(input logic [2:0] f_op, input logic f_w,
                                        input logic f_neg, input logic f_dz,
                                        input logic f_ovf, input dword_t f_acc,
                                        input word_t f_y, input word_t f_ext1);
    dword_t p;
    word_t  q;
    word_t  r;
    word_t  raw;
    p = '0;
    q = '0;
    r = '0;
    if (!f_op[2]) begin
      p   = f_neg ? -f_acc : f_acc;
      raw = (f_op == OP_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN];
    end else begin
      q = f_neg ? -f_y : f_y;
      r = f_neg ? -f_acc[XLEN-1:0] : f_acc[XLEN-1:0];
      if (f_dz) begin
        q = '1;
        r = f_ext1;
      end else if (f_ovf) begin
        q = f_ext1;
        r = '0;
      end
      raw = f_op[1] ? r : q;
    end
    return f_w ? ext32(raw[31:0], 1'b1) : raw;
  endfunction

  // Architectural state
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          w_q, w_d;
  logic          neg_q, neg_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;
  word_t         ext1_q, ext1_d;
  dword_t        acc_q, acc_d;     // product accumulator / remainder (low XLEN)
  dword_t        x_q, x_d;         // shifted multiplicand / divisor (low XLEN)
  word_t         y_q, y_d;         // multiplier digits / dividend -> quotient
  word_t         result_q, result_d;

  // Request decode (combinational on the request channel)
  logic          eff_w_i, sgn1_i, sgn2_i, sign1_i, sign2_i, neg_i, dz_i, ovf_i;
  word_t         ext1_i, ext2_i, mag1_i, mag2_i, min_i;
  logic [CW-1:0] steps_i;

  always_comb begin
    // W is ignored for MULH/MULHSU/MULHU.
    eff_w_i = w && (op == OP_MUL || op[2]);
    sgn1_i  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sgn2_i  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    ext1_i  = eff_w_i ? ext32(num1[31:0], sgn1_i) : num1;
    ext2_i  = eff_w_i ? ext32(num2[31:0], sgn2_i) : num2;
    sign1_i = sgn1_i && ext1_i[XLEN-1];
    sign2_i = sgn2_i && ext2_i[XLEN-1];
    mag1_i  = sign1_i ? -ext1_i : ext1_i;
    mag2_i  = sign2_i ? -ext2_i : ext2_i;
    // Remainders take the sign of the dividend. Everything else uses the XOR of the operand signs.
    neg_i   = (op[2] && op[1]) ? sign1_i : (sign1_i ^ sign2_i);
    min_i   = eff_w_i ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    dz_i    = op[2] && (ext2_i == '0);
    ovf_i   = op[2] && !op[0] && (ext1_i == min_i) && (ext2_i == '1);
    if (op[2]) steps_i = eff_w_i ? CW'(32) : CW'(XLEN);
    else       steps_i = eff_w_i ? CW'(32 / MUL_BITS) : CW'(XLEN / MUL_BITS);
  end

  // One datapath step for each operation class
  dword_t              mul_acc;
  logic [XLEN:0]       rem_shift, rem_diff;
  logic                q_bit;
  word_t               rem_next;

  assign mul_acc   = acc_q + x_q * PW'(y_q[MUL_BITS-1:0]);
  assign rem_shift = {acc_q[XLEN-1:0], y_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, x_q[XLEN-1:0]};
  assign q_bit     = ~rem_diff[XLEN];   // no borrow: divisor fits
  assign rem_next  = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first. Then no path can
    // leave it unassigned, and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    w_d      = w_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    ext1_d   = ext1_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = S_BUSY;
          cnt_d   = steps_i;
          op_d    = op;
          w_d     = eff_w_i;
          neg_d   = neg_i;
          dz_d    = dz_i;
          ovf_d   = ovf_i;
          ext1_d  = ext1_i;
          acc_d   = '0;
          if (op[2]) begin
            x_d = PW'(mag2_i);
            // A W dividend is moved to the top so that 32 steps consume exactly its bits.
            y_d = eff_w_i ? (mag1_i << (XLEN - 32)) : mag1_i;
          end else begin
            x_d = PW'(mag1_i);
            y_d = mag2_i;
          end
`ifdef YSYX_22040931_MDU_EARLY_OUT_EN
          if (op[2] ? (dz_i || ovf_i) : (ext1_i == '0 || ext2_i == '0)) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = form_result(op, eff_w_i, neg_i, dz_i, ovf_i, '0, '0, ext1_i);
          end
`endif
        end
      end

      S_BUSY: begin
        if (!op_q[2]) begin
          acc_d = mul_acc;
          x_d   = x_q << MUL_BITS;
          y_d   = y_q >> MUL_BITS;
        end else begin
          acc_d = PW'(rem_next);
          y_d   = {y_q[XLEN-2:0], q_bit};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = form_result(op_q, w_q, neg_q, dz_q, ovf_q, acc_d, y_d, ext1_q);
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      ext1_q   <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments give every register the value from
      // before the edge, whatever order the statements are in.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      w_q      <= w_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      ext1_q   <= ext1_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE) && !flush;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_result = result_q;

endmodule

// File: doc/ysyx_22040931_mdu.md
# ysyx_22040931_mdu

Parametrised multi-cycle multiply/divide unit for the RV64M execute stage. It covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the 32-bit W forms, and replaces the fixed-width single-purpose divider path. Operands arrive on a valid/ready request channel from the execute stage, and results return on a valid/ready response channel. One operation is in flight at a time, and a pipeline flush can kill it.

## Interface
- `XLEN`, default 64: operand/result width; must be 32 or 64.
- `MUL_BITS`, default 4: multiplier bits retired per cycle; must divide 32.
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `flush`, in, 1: synchronous kill of the in-flight or pending operation.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: `state==IDLE && !flush`.
- `op`, in, 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `w`, in, 1: 32-bit word form; honoured for op 0 and ops 4-7, ignored for ops 1-3.
- `num1`, in, XLEN: dividend / multiplicand.
- `num2`, in, XLEN: divisor / multiplier.
- `out_valid`, out, 1: result valid (`state==DONE`).
- `out_ready`, in, 1: consumer accepts the result.
- `out_result`, out, XLEN: registered result.
- `busy`, out, 1: `state != IDLE`.

## Operation
- **States**
  - IDLE --accept--> BUSY.
  - BUSY --last step--> DONE.
  - DONE --`out_ready`--> IDLE.
  - `flush` in any state --> IDLE.
- **Accept:** `in_valid && in_ready` at a rising edge. On that edge the unit latches:
  - operand magnitudes; for W forms, `num[31:0]` is sign- or zero-extended according to op signedness;
  - result sign and `op`/`w`;
  - the step counter.
- **Signedness**
  - MULH and DIV/REM are signed × signed.
  - MULHSU is signed `num1` × unsigned `num2`.
  - All other ops are unsigned.
- **Multiply:** unsigned shift-add on magnitudes, `MUL_BITS` per step.
  - Steps: `S = XLEN/MUL_BITS`, or `32/MUL_BITS` when `w`.
  - The 2·XLEN product is negated if the result sign is negative.
  - MUL takes `product[XLEN-1:0]`; MULH* take `product[2XLEN-1:XLEN]`; MULW takes `sext(product[31:0])`.
- **Divide:** restoring, 1 quotient bit per step.
  - Steps: `S = XLEN`, or 32 when `w`.
  - Quotient sign is `sign(num1) ^ sign(num2)`; remainder takes the sign of the dividend.
- **Special cases:** applied at the final step and override the datapath result.
  - Divisor zero: quotient = all ones (−1), remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
- **W results:** the 32-bit result is sign-extended to XLEN, including DIVUW/REMUW.
- **Result lifetime:** `out_result` is held stable while `out_valid && !out_ready`.
- **Flush**
  - Returns to IDLE on the next edge; `out_valid` is low from that edge on.
  - A result being handed off in the same cycle as `flush` is discarded by the consumer.
  - While `flush` is high, `in_valid` is never accepted.
- **Reset values:** state IDLE, `out_valid` 0, `out_result` 0, `busy` 0, `in_ready` 1 (with `flush` low), counter 0.

## Timing
- Accept edge E0. BUSY performs one step per edge, E1..ES.
- `out_valid` rises after edge ES; latency is S edges from acceptance.
  - With `XLEN=64`, `MUL_BITS=4`: MUL 16, MULW 8, DIV 64, DIVW 32.
- **Response handshake:** the handshake edge completes on `out_valid && out_ready` and returns the unit to IDLE.
  - `in_ready` is high in the following cycle, so there is a minimum one-cycle bubble between operations.
- `out_ready` may be held high before `out_valid`; the handshake completes on the first edge where both are high.
- `reset` asserted mid-operation clears immediately and asynchronously; no result is produced.

## Configuration
- `YSYX_22040931_MDU_EARLY_OUT_EN`
  - **Defined:** divide by zero, signed overflow, and any multiply with a zero operand skip BUSY and go IDLE→DONE on E0. `out_valid` is high one cycle after accept; the result is the special-case/zero value.
  - **Undefined:** all operations take the full S steps. Results are identical in both configurations; only latency differs.

## Test plan
1. **MUL, signed MULH** (`XLEN=64`, `MUL_BITS=4`)
   - MUL: `num1=7`, `num2=−3` → `out_result=0xFFFF_FFFF_FFFF_FFEB`, `out_valid` 16 edges after accept.
   - MULH: `num1=−1`, `num2=−1` → 0.
2. **DIVW/REMW, signed**
   - DIVW: `num1=0x0000_0000_FFFF_FFF9` (−7), `num2=2` → `0xFFFF_FFFF_FFFF_FFFD`, latency 32.
   - REMW on the same operands → `0xFFFF_FFFF_FFFF_FFFF`.
3. **Divide-by-zero and overflow**
   - DIV: `num1=5`, `num2=0` → −1.
   - REMU: `num1=5`, `num2=0` → 5.
   - DIV: `num1=0x8000_0000_0000_0000`, `num2=−1` → `0x8000_0000_0000_0000`.
   - REM on the same operands → 0.
   - Latency is 64 without the macro and 1 with it.
4. **Back-pressure**
   - Hold `out_ready=0` for 10 cycles after `out_valid` → `out_result` stable, `in_ready` 0.
   - Release → handshake, then `in_ready=1` in the next cycle.
5. **Flush**
   - Assert `flush` at step 20 of a DIVU → IDLE next edge, no `out_valid`.
   - A new MULHU `0xFFFF_FFFF_FFFF_FFFF × 2` accepted afterwards returns 1.
6. **Asynchronous reset**
   - Assert `reset` mid-MUL between clock edges → `out_valid`/`busy` go 0 immediately.
   - After release, `in_ready=1`.
